// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared constants and types for the MIPS fetch-side PC logic.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Default fetch address after reset (must be word aligned).
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Bytes per instruction word; sequential fetch advances by this amount.
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // PC sequencer states: BOOT is the single non-fetching cycle after reset.
  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pc_next_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_unit_if
//  Purpose  : Control/redirect bundle between decode/hazard logic and the
//             PC next-address unit, plus the fetch-side outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_next_unit_if #(
  parameter int CNT_W = 16
);

  // Requests from hazard unit and decode
  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_off;
  logic              jump;
  logic [25:0]       jump_index;
  logic [31:0]       id_pc_plus4;

  // Fetch-side and debug outputs
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic              fetch_valid;
  logic              flush;
  logic              align_err;
  logic [CNT_W-1:0]  redirect_cnt;

  // Requester side: drives control, observes fetch address.
  modport master (
    output stall, branch_taken, branch_off, jump, jump_index, id_pc_plus4,
    input  pc, pc_plus4, fetch_valid, flush, align_err, redirect_cnt
  );

  // PC unit side.
  modport slave (
    input  stall, branch_taken, branch_off, jump, jump_index, id_pc_plus4,
    output pc, pc_plus4, fetch_valid, flush, align_err, redirect_cnt
  );

endinterface : pc_next_unit_if
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
//  Module   : pc_target_calc
//  Purpose  : Combinational redirect target generation. Forms the branch and
//             jump targets, selects between them (jump first), and flags a
//             target whose low two bits are non-zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_target_calc
  import mips_pkg::*;
(
  input  wire logic        jump_i,
  input  wire logic        branch_taken_i,
  input  wire logic [31:0] branch_off_i,
  input  wire logic [25:0] jump_index_i,
  input  wire logic [31:0] id_pc_plus4_i,
  output logic             redirect_o,
  output logic [31:0]      target_o,
  output logic             misaligned_o
);

  logic [31:0] branch_target_w;
  logic [31:0] jump_target_w;
  logic [31:0] raw_target_w;

  // Target arithmetic and selection; the branch add wraps modulo 2^32.
  always_comb begin
    branch_target_w = id_pc_plus4_i + branch_off_i;
    jump_target_w   = {id_pc_plus4_i[31:28], jump_index_i, 2'b00};
    raw_target_w    = jump_i ? jump_target_w : branch_target_w;
    redirect_o      = jump_i | branch_taken_i;
    // Low bits are forced to zero so fetch stays word aligned even on a bad offset.
    target_o        = raw_target_w & ~(WORD_BYTES - 32'd1);
    misaligned_o    = redirect_o && (raw_target_w[1:0] != 2'b00);
  end

endmodule : pc_target_calc
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_unit
//  Purpose  : Program-counter register and next-PC arbitration
//             (jump > branch > stall > sequential), IF/ID flush pulse,
//             sticky misalignment flag and saturating redirect counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_next_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pc_next_unit_if.slave      bus
);

  pc_state_t        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             flush_q, flush_d;
  logic             align_err_q, align_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             redirect_w;
  logic [31:0]      target_w;
  logic             misaligned_w;

  pc_target_calc u_target (
    .jump_i         (bus.jump),
    .branch_taken_i (bus.branch_taken),
    .branch_off_i   (bus.branch_off),
    .jump_index_i   (bus.jump_index),
    .id_pc_plus4_i  (bus.id_pc_plus4),
    .redirect_o     (redirect_w),
    .target_o       (target_w),
    .misaligned_o   (misaligned_w)
  );

  // Next-state arbitration: redirect beats stall, stall beats sequential advance.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_plus4_d    = pc_plus4_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = 1'b0;
    align_err_d   = align_err_q;
    cnt_d         = cnt_q;
    case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN: begin
        fetch_valid_d = 1'b1;
        if (redirect_w) begin
          pc_d       = target_w;
          pc_plus4_d = target_w + WORD_BYTES;
          flush_d    = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (misaligned_w) begin
            align_err_d = 1'b1;
          end
        end else if (!bus.stall) begin
          // pc_plus4 already holds the sequential address, so reuse it.
          pc_d       = pc_plus4_q;
          pc_plus4_d = pc_plus4_q + WORD_BYTES;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and output registers; reset wins over every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + WORD_BYTES;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      align_err_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      align_err_q   <= align_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4_q;
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.flush        = flush_q;
  assign bus.align_err    = align_err_q;
  assign bus.redirect_cnt = cnt_q;

endmodule : pc_next_unit
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_next_unit
//  Purpose  : Scoreboard bench for pc_next_unit with directed vectors.
//             Driver queues expected outputs; monitor compares on negedge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;

  localparam int CNT_W = 2;

  logic clk;
  logic rst;

  pc_next_unit_if #(.CNT_W(CNT_W)) bus ();

  pc_next_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int               due;
    string            name;
    logic [31:0]      pc;
    logic             fv;
    logic             fl;
    logic             ae;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Apply one cycle of inputs and queue the outputs expected after that edge.
  task automatic drive(input string name, input logic r, input logic st,
                       input logic br, input logic [31:0] off,
                       input logic j, input logic [25:0] idx,
                       input logic [31:0] idpc,
                       input logic [31:0] epc, input logic efv, input logic efl,
                       input logic eae, input logic [CNT_W-1:0] ecnt);
    exp_t e;
    rst              = r;
    bus.stall        = st;
    bus.branch_taken = br;
    bus.branch_off   = off;
    bus.jump         = j;
    bus.jump_index   = idx;
    bus.id_pc_plus4  = idpc;
    e.due  = cyc + 1;
    e.name = name;
    e.pc   = epc;
    e.fv   = efv;
    e.fl   = efl;
    e.ae   = eae;
    e.cnt  = ecnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Quiet cycle: no requests, sequential advance expected.
  task automatic idle(input string name, input logic [31:0] epc, input logic efv,
                      input logic eae, input logic [CNT_W-1:0] ecnt);
    drive(name, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 32'h0,
          epc, efv, 1'b0, eae, ecnt);
  endtask

  // Monitor: compare every output against the entry due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [31:0] ep4;
      e   = q.pop_front();
      ep4 = e.pc + 32'd4;
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.due);
      end else if (bus.pc !== e.pc || bus.pc_plus4 !== ep4 || bus.fetch_valid !== e.fv ||
                   bus.flush !== e.fl || bus.align_err !== e.ae || bus.redirect_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s: got pc=%h p4=%h fv=%b fl=%b ae=%b cnt=%0d, required pc=%h p4=%h fv=%b fl=%b ae=%b cnt=%0d",
                 e.name, bus.pc, bus.pc_plus4, bus.fetch_valid, bus.flush, bus.align_err,
                 bus.redirect_cnt, e.pc, ep4, e.fv, e.fl, e.ae, e.cnt);
      end
    end
  end

  initial begin
    // Reset for two cycles, then boot and sequential fetch
    drive("rst0", 1, 0, 0, 32'h0, 0, 26'h0, 32'h0, 32'h0, 0, 0, 0, 2'd0);
    drive("rst1", 1, 0, 0, 32'h0, 0, 26'h0, 32'h0, 32'h0, 0, 0, 0, 2'd0);
    idle ("boot",   32'h0, 1, 0, 2'd0);
    idle ("seq4",   32'h4, 1, 0, 2'd0);
    idle ("seq8",   32'h8, 1, 0, 2'd0);

    // Backward branch: 0x100 + (-16) = 0xF0
    drive("branch", 0, 0, 1, 32'hFFFF_FFF0, 0, 26'h0, 32'h100,
          32'hF0, 1, 1, 0, 2'd1);
    idle ("br_after", 32'hF4, 1, 0, 2'd1);

    // Jump beats branch and stall, single count
    drive("jmp_all", 0, 1, 1, 32'h0000_1000, 1, 26'h000_0040, 32'h4000_0010,
          32'h4000_0100, 1, 1, 0, 2'd2);
    idle ("jmp_after", 32'h4000_0104, 1, 0, 2'd2);

    // Reach 0x20 with a branch, then stall three cycles
    drive("br_to20", 0, 0, 1, 32'h10, 0, 26'h0, 32'h10, 32'h20, 1, 1, 0, 2'd3);
    drive("stall0", 0, 1, 0, 32'h0, 0, 26'h0, 32'h0, 32'h20, 1, 0, 0, 2'd3);
    drive("stall1", 0, 1, 0, 32'h0, 0, 26'h0, 32'h0, 32'h20, 1, 0, 0, 2'd3);
    drive("stall2", 0, 1, 0, 32'h0, 0, 26'h0, 32'h0, 32'h20, 1, 0, 0, 2'd3);
    idle ("unstall", 32'h24, 1, 0, 2'd3);

    // Misaligned branch target 0xA -> fetch 0x8, sticky flag; counter saturated
    drive("misalign", 0, 0, 1, 32'h2, 0, 26'h0, 32'h8, 32'h8, 1, 1, 1, 2'd3);
    idle ("ae_hold",  32'hC, 1, 1, 2'd3);

    // Jump to top of memory, then wrap to zero
    drive("jmp_top", 0, 0, 0, 32'h0, 1, 26'h3FF_FFFF, 32'hF000_0000,
          32'hFFFF_FFFC, 1, 1, 1, 2'd3);
    idle ("wrap",    32'h0, 1, 1, 2'd3);
    idle ("ae_hold2", 32'h4, 1, 1, 2'd3);

    // Reset clears the sticky flag and counter
    drive("rst2", 1, 0, 0, 32'h0, 0, 26'h0, 32'h0, 32'h0, 0, 0, 0, 2'd0);
    idle ("boot2",  32'h0, 1, 0, 2'd0);

    // Back-to-back redirects saturate the 2-bit counter
    drive("b2b1", 0, 0, 1, 32'h0, 0, 26'h0, 32'h100, 32'h100, 1, 1, 0, 2'd1);
    drive("b2b2", 0, 0, 1, 32'h0, 0, 26'h0, 32'h100, 32'h100, 1, 1, 0, 2'd2);
    drive("b2b3", 0, 0, 1, 32'h0, 0, 26'h0, 32'h100, 32'h100, 1, 1, 0, 2'd3);
    drive("b2b4", 0, 0, 1, 32'h0, 0, 26'h0, 32'h100, 32'h100, 1, 1, 0, 2'd3);
    drive("b2b5", 0, 0, 1, 32'h0, 0, 26'h0, 32'h100, 32'h100, 1, 1, 0, 2'd3);

    // Reset mid-burst, then branch ignored during boot
    drive("rst_mid", 1, 0, 1, 32'h0, 1, 26'h1, 32'h100, 32'h0, 0, 0, 0, 2'd0);
    drive("boot_ign", 0, 0, 1, 32'h4, 1, 26'h1, 32'h100, 32'h0, 1, 0, 0, 2'd0);
    idle ("seq_after", 32'h4, 1, 0, 2'd0);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_next_unit
`default_nettype wire
